// File: rtl/pfd_tdc_5bit.sv
// Counter-based phase/frequency detector for the ADPLL input: timestamps ref/nco rising
// edges on clk and reports a sign-magnitude 5-bit phase error with update strobe and lock.
//
//   state    | meaning
//   IDLE     | no measurement open, waiting for the first of a ref/nco edge pair
//   WAIT_NCO | ref edge seen first, counting until the nco edge (NCO lags)
//   WAIT_REF | nco edge seen first, counting until the ref edge (NCO leads)
module pfd_tdc_5bit #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64,
  parameter int LOCK_TH = 1,
  parameter int LOCK_N  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       ref_in,
  input  logic       nco_in,
  output logic       ctrl_sign,
  output logic [4:0] ctrl,
  output logic       ctrl_valid,
  output logic       lock
);

  localparam int LCW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W:0] MAG_MAX = (CNT_W + 1)'(31);
  localparam logic [CNT_W:0] TMO     = (CNT_W + 1)'(TIMEOUT);
  localparam logic [4:0]     LTH     = 5'(LOCK_TH);
  localparam logic [LCW-1:0] LN      = LCW'(LOCK_N);

  typedef enum logic [1:0] {IDLE, WAIT_NCO, WAIT_REF} state_t;

  logic ref_s1_q, ref_s2_q, ref_d_q, ref_rise_q;
  logic nco_s1_q, nco_s2_q, nco_d_q, nco_rise_q;
  logic ref_rise_d, nco_rise_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W:0]   d_cur;
  logic             res_vld;
  logic [4:0]       res_mag;
  logic             res_sign;

  logic [4:0]     ctrl_q, ctrl_d;
  logic           ctrl_sign_q, ctrl_sign_d;
  logic           ctrl_valid_q, ctrl_valid_d;
  logic           lock_q, lock_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;

  always_comb begin
    ref_rise_d = ref_s2_q & ~ref_d_q;
    nco_rise_d = nco_s2_q & ~nco_d_q;
  end

  // Synchronizers and edge pulses run regardless of enable so re-enabling sees no stale edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_s1_q   <= 1'b0;
      ref_s2_q   <= 1'b0;
      ref_d_q    <= 1'b0;
      ref_rise_q <= 1'b0;
      nco_s1_q   <= 1'b0;
      nco_s2_q   <= 1'b0;
      nco_d_q    <= 1'b0;
      nco_rise_q <= 1'b0;
    end else begin
      ref_s1_q   <= ref_in;
      ref_s2_q   <= ref_s1_q;
      ref_d_q    <= ref_s2_q;
      ref_rise_q <= ref_rise_d;
      nco_s1_q   <= nco_in;
      nco_s2_q   <= nco_s1_q;
      nco_d_q    <= nco_s2_q;
      nco_rise_q <= nco_rise_d;
    end
  end

  // d_cur is the distance of the current cycle from the opening pulse (counter starts at 0).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_vld  = 1'b0;
    res_mag  = 5'd0;
    res_sign = 1'b0;
    d_cur    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (ref_rise_q && nco_rise_q) begin
            res_vld = 1'b1;
          end else if (ref_rise_q) begin
            state_d = WAIT_NCO;
          end else if (nco_rise_q) begin
            state_d = WAIT_REF;
          end
        end
        WAIT_NCO, WAIT_REF: begin
          cnt_d    = cnt_inc;
          res_sign = (state_q == WAIT_REF);
          if ((state_q == WAIT_NCO) ? nco_rise_q : ref_rise_q) begin
            res_vld = 1'b1;
            res_mag = (d_cur > MAG_MAX) ? 5'd31 : d_cur[4:0];
            state_d = IDLE;
            cnt_d   = '0;
          end else if ((state_q == WAIT_NCO) ? ref_rise_q : nco_rise_q) begin
            cnt_d = '0;
          end else if (d_cur >= TMO) begin
            res_vld = 1'b1;
            res_mag = 5'd31;
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    ctrl_d       = ctrl_q;
    ctrl_sign_d  = ctrl_sign_q;
    ctrl_valid_d = res_vld;
    lock_cnt_d   = lock_cnt_q;
    lock_d       = lock_q;
    if (res_vld) begin
      ctrl_d      = res_mag;
      ctrl_sign_d = res_sign;
      if (res_mag <= LTH) begin
        lock_cnt_d = (lock_cnt_q == LN) ? LN : lock_cnt_q + LCW'(1);
      end else begin
        lock_cnt_d = '0;
      end
      lock_d = (lock_cnt_d == LN);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ctrl_q       <= 5'd0;
      ctrl_sign_q  <= 1'b0;
      ctrl_valid_q <= 1'b0;
      lock_cnt_q   <= '0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ctrl_q       <= ctrl_d;
      ctrl_sign_q  <= ctrl_sign_d;
      ctrl_valid_q <= ctrl_valid_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_q       <= lock_d;
    end
  end

  assign ctrl       = ctrl_q;
  assign ctrl_sign  = ctrl_sign_q;
  assign ctrl_valid = ctrl_valid_q;
  assign lock       = lock_q;

endmodule
